// File: rtl/cic_frame_demux.sv
// cic_frame_demux
//   Sink end of the CIC decimator's channel-multiplexed stream. Collects one beat
//   per channel into a collect bank, checks the channel order and the sop/eop
//   framing, and presents each complete frame as one wide word. The design is
//   double-buffered: a collect bank and an output bank. Input only stalls when a
//   complete frame is parked in the collect bank and the output bank is still
//   occupied.
// Ports
//   clk, reset              : single rising-edge clock, synchronous active-high reset
//   in_data/in_channel      : sample and its channel index
//   in_startofpacket/eop    : framing flags (sop on ch0, eop on the last channel)
//   in_error                : per-beat error flags, ORed over the frame
//   in_valid/in_ready       : input handshake
//   out_data                : frame, channel k at [k*DATA_W +: DATA_W]
//   out_error               : OR of in_error over the frame's beats
//   out_valid/out_ready     : output handshake, frame held until accepted
//   drop_count              : saturating count of dropped frames and stray beats
module cic_frame_demux #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 16,
  parameter int CH_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CH_W-1:0]          in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [1:0]               in_error,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [1:0]               out_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               drop_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] FIRST_CH = '0;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [CH_W-1:0]           exp_ch_r;
  logic [CH_W-1:0]           exp_nxt_s;
  logic [NUM_CH*DATA_W-1:0]  slots_r;
  logic [1:0]                err_r;

  logic accept_s;
  logic out_free_s;
  logic start_ok_s;
  logic wr_slot_s;
  logic new_frame_s;
  logic drop_s;
  logic load_direct_s;
  logic load_bank_s;

  assign accept_s   = in_valid & in_ready;
  // The output bank can take a frame when empty or being emptied this cycle.
  assign out_free_s = ~out_valid | out_ready;
  assign start_ok_s = in_startofpacket & (in_channel == FIRST_CH) & ~in_endofpacket;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath-control decode.
  always_comb begin
    state_nxt_s   = state_r;
    exp_nxt_s     = exp_ch_r;
    wr_slot_s     = 1'b0;
    new_frame_s   = 1'b0;
    drop_s        = 1'b0;
    load_direct_s = 1'b0;
    load_bank_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (start_ok_s) begin
          wr_slot_s   = 1'b1;
          new_frame_s = 1'b1;
          exp_nxt_s   = CH_W'(1);
          state_nxt_s = COLLECT;
        end else begin
          drop_s = 1'b1;
        end
      end
      COLLECT: begin
        if (!accept_s) begin
          state_nxt_s = COLLECT;
        end else if (in_startofpacket) begin
          // A new sop aborts the partial frame; a well-formed one restarts it.
          drop_s = 1'b1;
          if (start_ok_s) begin
            wr_slot_s   = 1'b1;
            new_frame_s = 1'b1;
            exp_nxt_s   = CH_W'(1);
            state_nxt_s = COLLECT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (in_channel != exp_ch_r) begin
          drop_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if ((exp_ch_r != LAST_CH) && !in_endofpacket) begin
          wr_slot_s = 1'b1;
          exp_nxt_s = exp_ch_r + CH_W'(1);
        end else if ((exp_ch_r == LAST_CH) && in_endofpacket) begin
          if (out_free_s) begin
            // Last beat goes straight into the output bank with the stored slots.
            load_direct_s = 1'b1;
            state_nxt_s   = IDLE;
          end else begin
            wr_slot_s   = 1'b1;
            state_nxt_s = HOLD;
          end
        end else begin
          drop_s      = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        if (out_free_s) begin
          load_bank_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Input handshake: closed while a full frame is parked, and during reset.
  always_comb begin
    if (reset) begin
      in_ready = 1'b0;
    end else if (state_r == HOLD) begin
      in_ready = 1'b0;
    end else begin
      in_ready = 1'b1;
    end
  end

  // Collect bank, output bank and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_ch_r   <= '0;
      slots_r    <= '0;
      err_r      <= 2'b00;
      out_data   <= '0;
      out_error  <= 2'b00;
      out_valid  <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      exp_ch_r <= exp_nxt_s;
      if (wr_slot_s) begin
        slots_r[int'(in_channel)*DATA_W +: DATA_W] <= in_data;
      end
      if (new_frame_s) begin
        err_r <= in_error;
      end else if (wr_slot_s) begin
        err_r <= err_r | in_error;
      end
      if (load_direct_s) begin
        out_data  <= {in_data, slots_r[(NUM_CH-1)*DATA_W-1:0]};
        out_error <= err_r | in_error;
        out_valid <= 1'b1;
      end else if (load_bank_s) begin
        out_data  <= slots_r;
        out_error <= err_r;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop_s && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule
